// File: rtl/fetch_decode_unit_if.sv
// Bundle of program-load, run-control and ALU-issue signals for fetch_decode_unit.
// The DUT uses the slave modport; the driver of loads, runs and out_ready uses master.
interface fetch_decode_unit_if #(
    parameter int DEPTH = 16,
    parameter int IW    = 19
) ();
    localparam int PC_W = $clog2(DEPTH);

    logic            load_en;
    logic [PC_W-1:0] load_addr;
    logic [IW-1:0]   load_data;
    logic [PC_W:0]   prog_len;
    logic            start;
    logic            abort;
    logic            out_ready;
    logic            out_valid;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [2:0]      opcode;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            done;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, abort, out_ready,
        input  out_valid, a, b, opcode, pc, busy, done
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, abort, out_ready,
        output out_valid, a, b, opcode, pc, busy, done
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// Program store plus IDLE/FETCH/ISSUE/DONE sequencer that feeds decoded words to an ALU stage.
// Build macro FDU_LOOP_EN: the program repeats from address 0 until abort instead of finishing.
module fetch_decode_unit #(
    parameter int DEPTH = 16,
    parameter int IW    = 19
) (
    input  logic               clk,
    input  logic               rst,
    fetch_decode_unit_if.slave bus
);
    localparam int PC_W  = $clog2(DEPTH);
    localparam int LEN_W = PC_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    mem_q [DEPTH];
    logic [IW-1:0]    mem_d [DEPTH];
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             last;
    logic [IW-1:0]    fetch_word;

    assign handshake  = valid_q & bus.out_ready;
    assign last       = ({1'b0, pc_q} == (len_q - LEN_W'(1)));
    assign fetch_word = mem_q[pc_q];

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        pc_d     = pc_q;
        len_d    = len_q;
        opcode_d = opcode_q;
        a_d      = a_q;
        b_d      = b_q;
        valid_d  = valid_q;
        done_d   = 1'b0;

        // The store is written at the same edge that accepts start, so a run sees a same-cycle load.
        if (state_q == IDLE && bus.load_en) begin
            mem_d[bus.load_addr] = bus.load_data;
        end

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.prog_len != '0) begin
                            len_d   = bus.prog_len;
                            pc_d    = '0;
                            state_d = FETCH;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    opcode_d = fetch_word[IW-1 -: 3];
                    a_d      = fetch_word[15:8];
                    b_d      = fetch_word[7:0];
                    valid_d  = 1'b1;
                    state_d  = ISSUE;
                end
                ISSUE: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        if (!last) begin
                            pc_d    = pc_q + PC_W'(1);
                            state_d = FETCH;
                        end else begin
`ifdef FDU_LOOP_EN
                            pc_d    = '0;
                            state_d = FETCH;
`else
                            state_d = DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == FETCH) || (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pc_q     <= '0;
            len_q    <= '0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            opcode_q <= opcode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.opcode    = opcode_q;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.pc        = pc_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomized self-checking bench for fetch_decode_unit against a program-level reference model.
module tb_fetch_decode_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [18:0] mem_m [16];

    fetch_decode_unit_if bus ();

    fetch_decode_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [18:0] w);
        bus.load_en   = 1'b1;
        bus.load_addr = addr[3:0];
        bus.load_data = w;
        step();
        bus.load_en = 1'b0;
        mem_m[addr] = w;
    endtask

    // Loads attempted while a run is in progress; the model must ignore them.
    task automatic noise();
        bus.load_en   = 1'($urandom_range(0, 1));
        bus.load_addr = 4'($urandom_range(0, 15));
        bus.load_data = 19'($urandom);
    endtask

    function automatic logic [31:0] word_out();
        return 32'({bus.opcode, bus.a, bus.b});
    endfunction

    // mode 1 holds out_ready high; mode 0 randomizes it. stall0 forces initial stall cycles.
    task automatic run(input int len, input int mode, input int stall0);
        int idx;
        int stalls;
        logic rdy;
        stalls = stall0;
        bus.prog_len = len[4:0];
        bus.start    = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        if (len == 0) begin
            chk("zero_done", 32'(bus.done), 32'd1);
            chk("zero_valid", 32'(bus.out_valid), 32'd0);
            step();
            chk("zero_done_end", 32'(bus.done), 32'd0);
            chk("zero_valid_end", 32'(bus.out_valid), 32'd0);
            return;
        end
        chk("fetch_busy", 32'(bus.busy), 32'd1);
        chk("fetch_valid", 32'(bus.out_valid), 32'd0);
        noise();
        step();
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        idx = 0;
        while (idx < len) begin
            chk("word", word_out(), 32'(mem_m[idx]));
            chk("pc", 32'(bus.pc), 32'(idx));
            chk("valid", 32'(bus.out_valid), 32'd1);
            if (stalls > 0) begin
                bus.out_ready = 1'b0;
                stalls--;
            end else begin
                bus.out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            rdy = bus.out_ready;
            noise();
            step();
            if (rdy) begin
                bus.out_ready = 1'b0;
                chk("clear_valid", 32'(bus.out_valid), 32'd0);
                idx++;
                if (idx < len) begin
                    chk("refetch_busy", 32'(bus.busy), 32'd1);
                    chk("refetch_pc", 32'(bus.pc), 32'(idx));
                    noise();
                    step();
                    chk("issue_valid", 32'(bus.out_valid), 32'd1);
                end
            end
        end
        bus.load_en = 1'b0;
`ifdef FDU_LOOP_EN
        chk("loop_no_done", 32'(bus.done), 32'd0);
        chk("loop_busy", 32'(bus.busy), 32'd1);
        chk("loop_pc", 32'(bus.pc), 32'd0);
        step();
        chk("loop_valid", 32'(bus.out_valid), 32'd1);
        chk("loop_word", word_out(), 32'(mem_m[0]));
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("loop_abort_valid", 32'(bus.out_valid), 32'd0);
        chk("loop_abort_busy", 32'(bus.busy), 32'd0);
`else
        chk("run_done", 32'(bus.done), 32'd1);
        chk("run_busy_end", 32'(bus.busy), 32'd0);
        step();
        chk("run_done_pulse", 32'(bus.done), 32'd0);
`endif
    endtask

    initial begin
        rst           = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        step();
        step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_word", word_out(), 32'd0);
        #2 rst = 1'b1;
        step();

        // Two-instruction program, free-flowing then back-pressured.
        load(0, {3'b000, 8'h05, 8'h03});
        load(1, {3'b001, 8'hCC, 8'hAA});
        run(2, 1, 0);
        run(2, 1, 5);
        run(0, 1, 0);

        // Load and start in the same cycle.
        bus.load_en   = 1'b1;
        bus.load_addr = 4'd0;
        bus.load_data = {3'b101, 8'h12, 8'h34};
        mem_m[0]      = {3'b101, 8'h12, 8'h34};
        run(1, 1, 0);

        // Abort while instruction 1 of 3 is on offer, racing a handshake.
        load(2, {3'b111, 8'h77, 8'h88});
        bus.prog_len = 5'd3;
        bus.start    = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        chk("abort_pre_pc", 32'(bus.pc), 32'd1);
        chk("abort_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        step();
        chk("abort_no_done", 32'(bus.done), 32'd0);
        load(0, {3'b010, 8'hF0, 8'h0F});
        run(1, 1, 0);

        // Asynchronous reset in the middle of a run.
        bus.prog_len  = 5'd16;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus.out_ready = 1'b0;
        chk("rst_mid_pre_pc", 32'(bus.pc), 32'd2);
        chk("rst_mid_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_pc", 32'(bus.pc), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        step();
        #2 rst = 1'b1;
        step();
        chk("rst_rel_done", 32'(bus.done), 32'd0);
        run(16, 1, 0);

        // Random programs, lengths and back-pressure.
        for (int r = 0; r < 25; r++) begin
            int nl;
            nl = $urandom_range(0, 6);
            for (int k = 0; k < nl; k++) load($urandom_range(0, 15), 19'($urandom));
            run($urandom_range(0, 16), 0, $urandom_range(0, 2));
        end
        run(16, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, the number of program-store entries; the PC width is log2(DEPTH) = 4 bits.
REQ-002 The block SHALL have parameter IW, default 19, the instruction width {opcode[18:16], a[15:8], b[7:0]}.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load_en  input  1  program-store write strobe.
REQ-006 load_addr  input  4  program-store write address.
REQ-007 load_data  input  19  instruction word to write.
REQ-008 prog_len  input  5  number of instructions to issue, 0..16; sampled at start.
REQ-009 start  input  1  begin issuing from address 0.
REQ-010 abort  input  1  terminate the current run.
REQ-011 out_ready  input  1  the downstream ALU stage accepts the current instruction.
REQ-012 out_valid  output  1  a, b and opcode hold a valid instruction.
REQ-013 a  output  8  operand A for the ALU.
REQ-014 b  output  8  operand B for the ALU.
REQ-015 opcode  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 compare.
REQ-016 pc  output  4  address of the instruction currently held or being fetched.
REQ-017 busy  output  1  high in the FETCH and ISSUE states.
REQ-018 done  output  1  one-cycle pulse at the end of a run.

Function
REQ-019 The FSM SHALL have four states: IDLE, FETCH, ISSUE and DONE.
REQ-020 In IDLE, load_en SHALL write load_data to mem[load_addr]; load_en in any other state SHALL be ignored.
REQ-021 In IDLE, start with prog_len != 0 SHALL latch prog_len, set pc = 0 and move to FETCH; start with prog_len == 0 SHALL go directly to DONE.
REQ-022 In IDLE, a load_en and start in the same cycle SHALL perform the write first, so the run sees the new word.
REQ-023 In FETCH (one cycle), the block SHALL register mem[pc] into opcode, a and b, then move to ISSUE with out_valid = 1.
REQ-024 In ISSUE, opcode, a, b and pc SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-025 An ISSUE handshake (out_valid & out_ready) SHALL clear out_valid the next cycle.
REQ-026 After a handshake with pc != prog_len-1, the block SHALL set pc = pc+1 and return to FETCH.
REQ-027 After a handshake with pc == prog_len-1, the block SHALL move to DONE, subject to REQ-036.
REQ-028 The cycle latency from start to the first out_valid SHALL be 2 clocks.
REQ-029 With out_ready held high, the block SHALL issue at most one instruction every 2 clocks.
REQ-030 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-031 abort high in any state other than IDLE SHALL force IDLE on the next edge, with out_valid = 0 and no done pulse; abort SHALL take priority over a handshake in the same cycle.
REQ-032 start while busy SHALL be ignored.
REQ-033 The pc increment SHALL be 4-bit modulo; with prog_len = 16 the last address is 15.

Reset
REQ-034 While rst = 0, the block SHALL asynchronously force: state = IDLE, pc = 0, out_valid = 0, busy = 0, done = 0, a = b = 0, opcode = 000, latched length = 0.
REQ-035 Reset SHALL clear every mem entry to 0, and reset mid-run SHALL abandon the run with no done pulse.

Configuration
REQ-036 Macro FDU_LOOP_EN: when defined, a handshake at pc == prog_len-1 SHALL set pc = 0 and go to FETCH, so the run repeats until abort and DONE is never reached from ISSUE; when undefined, the block SHALL behave as REQ-027.

Verification
REQ-037 Load mem[0] = {000,05,03} and mem[1] = {001,CC,AA}, prog_len = 2, start, out_ready = 1 -> out_valid at start+2 with a=05, b=03, op=000; then a=CC, b=AA, op=001; then a single done pulse.
REQ-038 Same program with out_ready held low for 5 cycles -> outputs stay at {000,05,03} with out_valid high for all 5 cycles and pc = 0; the second instruction follows the release.
REQ-039 start with prog_len = 0 -> done pulses 1 cycle after start and out_valid never rises.
REQ-040 abort asserted during ISSUE of instruction 1 of 3 -> out_valid = 0 and state IDLE next cycle, no done pulse; load_en then writes successfully.
REQ-041 rst pulled low mid-run, asynchronously -> out_valid, busy and pc drop to 0 immediately; mem reads back 0 after release.
REQ-042 With FDU_LOOP_EN defined, prog_len = 2 and out_ready = 1 -> pc sequence 0,1,0,1,... with no done pulse until abort.
